pwm_regs_mc: RTL and testbench

Multi-channel, width-parametrised register file for the PWM generator. Sits between the SPI/bus decoder and NUM_CH counter/PWM channel pairs. Exposes per-channel timing, compare and control registers over a byte-wide read/write port. Adds double-buffered (shadow) period/compare registers, coherent multi-byte counter snapshots and a self-clearing counter reset pulse.

---
 rtl/pwm_regs_mc.sv | 254 +++++++++++++++++++++++++
 tb/tb_pwm_regs_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_regs_mc.sv
// pwm_regs_mc: per-channel PWM period/compare/control register file.
// Optional double-buffered PERIOD/COMPAREx when PWM_REGS_SHADOW_EN is defined.
module pwm_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  localparam int CH_AW = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH),
  localparam int ADDR_W = CH_AW + 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               data_write,
  output logic [7:0]               data_read,
  input  logic [NUM_CH*CNT_W-1:0]  counter_val,
  input  logic [NUM_CH-1:0]        period_end,
  output logic [NUM_CH*CNT_W-1:0]  period,
  output logic [NUM_CH*CNT_W-1:0]  compare1,
  output logic [NUM_CH*CNT_W-1:0]  compare2,
  output logic [NUM_CH-1:0]        en,
  output logic [NUM_CH-1:0]        upnotdown,
  output logic [NUM_CH-1:0]        pwm_en,
  output logic [NUM_CH-1:0]        count_reset,
  output logic [NUM_CH*8-1:0]      prescale,
  output logic [NUM_CH*2-1:0]      functions
);

  localparam int BYTES = CNT_W / 8;

  typedef logic [CNT_W-1:0] word_t;

  function automatic word_t put_byte(
    input word_t      w,
    input logic [1:0] k,
    input logic [7:0] d
  );
    word_t r;
    r = w;
    for (int b = 0; b < BYTES; b++)
      if (k == 2'(b)) r[b*8 +: 8] = d;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(
    input word_t      w,
    input logic [1:0] k
  );
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++)
      if (k == 2'(b)) r = w[b*8 +: 8];
    return r;
  endfunction

  logic [CH_AW-1:0] ch_idx;
  logic [2:0]       grp;
  logic [1:0]       kb;
  logic             is_per;
  logic             is_c1;
  logic             is_c2;
  logic             is_cnt;
  logic             is_ctl;

  assign ch_idx = addr[ADDR_W-1:5];
  assign grp    = addr[4:2];
  assign kb     = addr[1:0];
  assign is_per = (grp == 3'd0);
  assign is_c1  = (grp == 3'd1);
  assign is_c2  = (grp == 3'd2);
  assign is_cnt = (grp == 3'd3);
  assign is_ctl = (grp == 3'd4);

  word_t per_sh  [NUM_CH];
  word_t c1_sh   [NUM_CH];
  word_t c2_sh   [NUM_CH];
  word_t per_act [NUM_CH];
  word_t c1_act  [NUM_CH];
  word_t c2_act  [NUM_CH];
  word_t snap    [NUM_CH];

  logic [7:0] presc_q [NUM_CH];
  logic [1:0] func_q  [NUM_CH];
  logic [1:0] crst_q  [NUM_CH];

  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] ud_q;
  logic [NUM_CH-1:0] pe_q;
  logic [NUM_CH-1:0] pend;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] wr_per;
  logic [NUM_CH-1:0] wr_c1;
  logic [NUM_CH-1:0] wr_c2;
  logic [NUM_CH-1:0] wr_ctl;
  logic [NUM_CH-1:0] wr_psc;
  logic [NUM_CH-1:0] wr_fn;
  logic [NUM_CH-1:0] rd_snap;
  logic [7:0]        rd_byte;

  // Channel numbers beyond NUM_CH match no sel bit, so they decode to nothing.
  always_comb begin
    sel     = '0;
    wr_per  = '0;
    wr_c1   = '0;
    wr_c2   = '0;
    wr_ctl  = '0;
    wr_psc  = '0;
    wr_fn   = '0;
    rd_snap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]     = (int'(ch_idx) == c);
      wr_per[c]  = write && sel[c] && is_per;
      wr_c1[c]   = write && sel[c] && is_c1;
      wr_c2[c]   = write && sel[c] && is_c2;
      wr_ctl[c]  = write && sel[c] && is_ctl && (kb == 2'd0);
      wr_psc[c]  = write && sel[c] && is_ctl && (kb == 2'd1);
      wr_fn[c]   = write && sel[c] && is_ctl && (kb == 2'd2);
      rd_snap[c] = read && sel[c] && is_cnt && (kb == 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        per_sh[c]  <= '0;
        c1_sh[c]   <= '0;
        c2_sh[c]   <= '0;
        snap[c]    <= '0;
        presc_q[c] <= '0;
        func_q[c]  <= '0;
        crst_q[c]  <= '0;
      end
      en_q <= '0;
      ud_q <= '0;
      pe_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_per[c]) per_sh[c] <= put_byte(per_sh[c], kb, data_write);
        if (wr_c1[c])  c1_sh[c]  <= put_byte(c1_sh[c], kb, data_write);
        if (wr_c2[c])  c2_sh[c]  <= put_byte(c2_sh[c], kb, data_write);
        if (rd_snap[c]) snap[c] <= counter_val[c*CNT_W +: CNT_W];
        if (wr_ctl[c]) begin
          en_q[c] <= data_write[0];
          ud_q[c] <= data_write[1];
          pe_q[c] <= data_write[2];
        end
        if (wr_psc[c]) presc_q[c] <= data_write;
        if (wr_fn[c])  func_q[c]  <= data_write[1:0];
        // Two-cycle counter reset pulse; a fresh write restarts it.
        if (wr_ctl[c] && data_write[3])
          crst_q[c] <= 2'd2;
        else if (crst_q[c] != 2'd0)
          crst_q[c] <= crst_q[c] - 2'd1;
      end
    end
  end

`ifdef PWM_REGS_SHADOW_EN
  logic [NUM_CH-1:0] xfer;
  logic [NUM_CH-1:0] wr_any;

  always_comb begin
    xfer   = '0;
    wr_any = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      xfer[c]   = period_end[c] || !en_q[c];
      wr_any[c] = wr_per[c] || wr_c1[c] || wr_c2[c];
    end
  end

  // Active copies take the pre-write shadow when a write collides with a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        per_act[c] <= '0;
        c1_act[c]  <= '0;
        c2_act[c]  <= '0;
      end
      pend <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (xfer[c]) begin
          per_act[c] <= per_sh[c];
          c1_act[c]  <= c1_sh[c];
          c2_act[c]  <= c2_sh[c];
        end
        if (wr_any[c])
          pend[c] <= 1'b1;
        else if (xfer[c])
          pend[c] <= 1'b0;
      end
    end
  end
`else
  logic unused_period_end;

  assign unused_period_end = ^period_end;

  always_comb begin
    pend = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      per_act[c] = per_sh[c];
      c1_act[c]  = c1_sh[c];
      c2_act[c]  = c2_sh[c];
    end
  end
`endif

  always_comb begin
    rd_byte = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        unique case (1'b1)
          is_per: rd_byte = get_byte(per_sh[c], kb);
          is_c1:  rd_byte = get_byte(c1_sh[c], kb);
          is_c2:  rd_byte = get_byte(c2_sh[c], kb);
          is_cnt: rd_byte = (kb == 2'd0) ?
                            counter_val[c*CNT_W +: 8] :
                            get_byte(snap[c], kb);
          is_ctl: begin
            case (kb)
              2'd0:    rd_byte = {5'd0, pe_q[c], ud_q[c], en_q[c]};
              2'd1:    rd_byte = presc_q[c];
              2'd2:    rd_byte = {6'd0, func_q[c]};
              default: rd_byte = {7'd0, pend[c]};
            endcase
          end
          default: rd_byte = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_read <= '0;
    else if (read)
      data_read <= rd_byte;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign period[c*CNT_W +: CNT_W]   = per_act[c];
    assign compare1[c*CNT_W +: CNT_W] = c1_act[c];
    assign compare2[c*CNT_W +: CNT_W] = c2_act[c];
    assign prescale[c*8 +: 8]         = presc_q[c];
    assign functions[c*2 +: 2]        = func_q[c];
    assign en[c]                      = en_q[c];
    assign upnotdown[c]               = ud_q[c];
    assign pwm_en[c]                  = pe_q[c];
    assign count_reset[c]             = (crst_q[c] != 2'd0);
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// tb_pwm_regs_mc: vector table plus read scoreboard for pwm_regs_mc.
// A 3-channel copy on the same bus exercises out-of-range channel decode.
`timescale 1ns/1ps
module tb_pwm_regs_mc;

  localparam int NCH = 4;
  localparam int CW  = 16;

`ifdef PWM_REGS_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [6:0]      addr = '0;
  logic [7:0]      data_write = '0;
  logic [NCH*CW-1:0] counter_val = '0;
  logic [NCH-1:0]  period_end = '0;

  logic [7:0]        data_read;
  logic [NCH*CW-1:0] period, compare1, compare2;
  logic [NCH-1:0]    en, upnotdown, pwm_en, count_reset;
  logic [NCH*8-1:0]  prescale;
  logic [NCH*2-1:0]  functions;

  logic [7:0]  dr3;
  logic [47:0] p3, c13, c23;
  logic [2:0]  en3, ud3, pe3, cr3;
  logic [23:0] ps3;
  logic [5:0]  fn3;

  pwm_regs_mc #(.NUM_CH(NCH), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .addr(addr), .data_write(data_write), .data_read(data_read),
    .counter_val(counter_val), .period_end(period_end),
    .period(period), .compare1(compare1), .compare2(compare2),
    .en(en), .upnotdown(upnotdown), .pwm_en(pwm_en),
    .count_reset(count_reset), .prescale(prescale),
    .functions(functions)
  );

  pwm_regs_mc #(.NUM_CH(3), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .addr(addr), .data_write(data_write), .data_read(dr3),
    .counter_val(counter_val[47:0]), .period_end(period_end[2:0]),
    .period(p3), .compare1(c13), .compare2(c23),
    .en(en3), .upnotdown(ud3), .pwm_en(pe3),
    .count_reset(cr3), .prescale(ps3), .functions(fn3)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] e4;
    logic [7:0] e3;
  } rexp_t;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] e4;
    logic [7:0] e3;
  } vec_t;

  rexp_t q[$];
  vec_t  vt[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    rd_d = 1'b0;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", n, got, exp);
    end
  endtask

  always @(posedge clk) rd_d <= read;

  always @(negedge clk) begin
    if (rd_d) begin
      if (q.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        rexp_t r;
        r = q.pop_front();
        chk(r.name, 64'(data_read), 64'(r.e4));
        chk({r.name, "_ch3"}, 64'(dr3), 64'(r.e3));
      end
    end
  end

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    write = 1'b1;
    addr = a;
    data_write = d;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic rd(input string n, input logic [6:0] a,
                    input logic [7:0] e4, input logic [7:0] e3);
    read = 1'b1;
    addr = a;
    q.push_back('{name: n, e4: e4, e3: e3});
    @(posedge clk);
    #1;
    read = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] a, input logic [7:0] d,
                     input logic [7:0] e4, input logic [7:0] e3);
    vt.push_back('{a: a, d: d, e4: e4, e3: e3});
  endtask

  initial begin
    add(7'h11, 8'hA5, 8'hA5, 8'hA5);
    add(7'h12, 8'hFF, 8'h03, 8'h03);
    add(7'h10, 8'h0E, 8'h06, 8'h06);
    add(7'h14, 8'h5A, 8'h00, 8'h00);
    add(7'h1F, 8'hFF, 8'h00, 8'h00);
    add(7'h02, 8'h99, 8'h00, 8'h00);
    add(7'h0D, 8'h77, 8'h00, 8'h00);
    add(7'h13, 8'hFF, 8'h00, 8'h00);
    add(7'h00, 8'h34, 8'h34, 8'h34);
    add(7'h01, 8'h12, 8'h12, 8'h12);
    add(7'h44, 8'hC3, 8'hC3, 8'hC3);
    add(7'h69, 8'h5E, 8'h5E, 8'h00);
    add(7'h71, 8'h10, 8'h10, 8'h00);

    repeat (2) tick();
    chk("rst_held_outs", 64'(|{period, compare1, compare2, en,
        upnotdown, pwm_en, count_reset, prescale, functions}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_outs", 64'(|{period, compare1, compare2, en, upnotdown,
        pwm_en, count_reset, prescale, functions, data_read}), 64'd0);
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 20; o++)
        rd($sformatf("rst_c%0d_o%0h", c, o), 7'(c*32 + o), 8'h00, 8'h00);

    for (int i = 0; i < vt.size(); i++) begin
      wr(vt[i].a, vt[i].d);
      rd($sformatf("vec%0d", i), vt[i].a, vt[i].e4, vt[i].e3);
    end
    chk("out_period0", 64'(period[15:0]), 64'h1234);
    chk("out_psc0", 64'(prescale[7:0]), 64'hA5);
    chk("out_fn0", 64'(functions[1:0]), 64'h3);
    chk("out_ctl0", 64'({en[0], upnotdown[0], pwm_en[0]}), 64'b011);
    chk("out_cmp1_2", 64'(compare1[47:32]), 64'h00C3);
    chk("out_cmp2_3", 64'(compare2[63:48]), 64'h5E00);
    chk("out_psc3", 64'(prescale[31:24]), 64'h10);
    chk("ch3_psc", 64'(ps3), 64'h0000A5);
    chk("ch3_cmp2", 64'(c23), 64'h0);
    chk("ch3_cmp1_2", 64'(c13[47:32]), 64'h00C3);

    wr(7'h30, 8'h01);
    wr(7'h20, 8'h34);
    wr(7'h21, 8'h12);
    chk("sh_hold", 64'(period[31:16]), SH ? 64'h0 : 64'h1234);
    rd("sh_stat", 7'h33, SH ? 8'h01 : 8'h00, SH ? 8'h01 : 8'h00);
    repeat (2) tick();
    chk("sh_hold2", 64'(period[31:16]), SH ? 64'h0 : 64'h1234);
    period_end[1] = 1'b1;
    tick();
    period_end[1] = 1'b0;
    chk("sh_xfer", 64'(period[31:16]), 64'h1234);
    rd("sh_stat_clr", 7'h33, 8'h00, 8'h00);

    write = 1'b1;
    addr = 7'h20;
    data_write = 8'h78;
    period_end[1] = 1'b1;
    tick();
    write = 1'b0;
    period_end[1] = 1'b0;
    chk("col_active", 64'(period[31:16]), SH ? 64'h1234 : 64'h1278);
    rd("col_stat", 7'h33, SH ? 8'h01 : 8'h00, SH ? 8'h01 : 8'h00);
    rd("col_shadow", 7'h20, 8'h78, 8'h78);
    period_end[1] = 1'b1;
    tick();
    period_end[1] = 1'b0;
    chk("col_xfer", 64'(period[31:16]), 64'h1278);
    rd("col_stat_clr", 7'h33, 8'h00, 8'h00);

    wr(7'h04, 8'h55);
    tick();
    chk("dis_cmp1", 64'(compare1[15:0]), 64'h0055);

    counter_val[47:32] = 16'hABCD;
    rd("snap_b0", 7'h4C, 8'hCD, 8'hCD);
    counter_val[47:32] = 16'h0000;
    rd("snap_b1", 7'h4D, 8'hAB, 8'hAB);
    rd("snap_b2", 7'h4E, 8'h00, 8'h00);

    read = 1'b1;
    write = 1'b1;
    addr = 7'h11;
    data_write = 8'h3C;
    q.push_back('{name: "rw_pre", e4: 8'hA5, e3: 8'hA5});
    tick();
    read = 1'b0;
    write = 1'b0;
    rd("rw_post", 7'h11, 8'h3C, 8'h3C);

    wr(7'h70, 8'h08);
    chk("crst_c1", 64'(count_reset[3]), 64'd1);
    chk("crst_ch3_none", 64'(cr3), 64'd0);
    tick();
    chk("crst_c2", 64'(count_reset[3]), 64'd1);
    tick();
    chk("crst_c3", 64'(count_reset[3]), 64'd0);
    rd("crst_reads0", 7'h70, 8'h00, 8'h00);

    wr(7'h70, 8'h08);
    chk("crst_r1", 64'(count_reset[3]), 64'd1);
    wr(7'h70, 8'h08);
    chk("crst_r2", 64'(count_reset[3]), 64'd1);
    tick();
    chk("crst_r3", 64'(count_reset[3]), 64'd1);
    tick();
    chk("crst_r4", 64'(count_reset[3]), 64'd0);

    wr(7'h70, 8'h08);
    chk("mid_pulse", 64'(count_reset[3]), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_crst", 64'(count_reset), 64'd0);
    chk("mid_rst_outs", 64'(|{period, compare1, prescale, functions,
        data_read}), 64'd0);
    rst_n = 1'b1;
    tick();
    rd("post_rst_psc", 7'h11, 8'h00, 8'h00);
    rd("post_rst_per", 7'h20, 8'h00, 8'h00);

    repeat (2) tick();
    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
